// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 16-bit binary to 4-digit packed BCD converter
// (shift-and-add-3 over 16 shift cycles) feeding a seven-segment display driver.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   clr    in   1   asynchronous active-low reset
//   start  in   1   conversion request, honoured only while busy=0
//   bin    in  16   unsigned value, sampled on the accepting edge only
//   busy   out  1   conversion in progress (decode of the state register)
//   done   out  1   one-cycle pulse when bcd/ovf update
//   bcd    out 16   {thousands, hundreds, tens, ones}, held between conversions
//   ovf    out  1   last converted input exceeded 9999, held with bcd
module bin2bcd_seq (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        ovf
);

  localparam int unsigned BIN_W  = 16;
  localparam int unsigned DIGITS = 5;
  localparam int unsigned SCR_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned OUT_W  = 16;
  localparam logic [OUT_W-1:0] OVF_CODE  = 16'hEEEE;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   bin_sr, bin_sr_nxt;
  logic [SCR_W-1:0]   scr, scr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [OUT_W-1:0]   bcd_nxt;
  logic               ovf_nxt;
  logic               done_nxt;

  // Per-nibble +3 correction, independent nibbles (no carry between digits)
  logic [SCR_W-1:0]   scr_adj;
  logic               overflow;

  always_comb begin
    scr_adj = scr;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scr[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
      end
    end
  end

  // Any non-zero ten-thousands digit means the value is above 9999
  assign overflow = (scr[SCR_W-1 -: 4] != 4'd0);

  // State and datapath registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= IDLE;
      bin_sr <= '0;
      scr    <= '0;
      cnt    <= '0;
      bcd    <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      bin_sr <= bin_sr_nxt;
      scr    <= scr_nxt;
      cnt    <= cnt_nxt;
      bcd    <= bcd_nxt;
      ovf    <= ovf_nxt;
      done   <= done_nxt;
    end
  end

  // Next-state and next-value logic
  always_comb begin
    state_nxt  = state;
    bin_sr_nxt = bin_sr;
    scr_nxt    = scr;
    cnt_nxt    = cnt;
    bcd_nxt    = bcd;
    ovf_nxt    = ovf;
    done_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          bin_sr_nxt = bin;
          scr_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt == LAST_SHIFT) begin
          // Output edge: publish the whole result at once
          ovf_nxt   = overflow;
          bcd_nxt   = overflow ? OVF_CODE : scr[OUT_W-1:0];
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          // Correct then shift {scr,bin_sr} left; bin_sr MSB enters scr LSB
          {scr_nxt, bin_sr_nxt} = {scr_adj[SCR_W-2:0], bin_sr, 1'b0};
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: latency-counter reference model plus
// directed boundary, overlap, back-to-back, reset-abort and sweep vectors.
module tb_bin2bcd_seq;

  logic        clk;
  logic        clr;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  bin2bcd_seq dut (
    .clk  (clk),
    .clr  (clr),
    .start(start),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .bcd  (bcd),
    .ovf  (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Golden conversion: {ovf, bcd} from plain decimal arithmetic
  function automatic logic [16:0] golden(input int unsigned v);
    logic [3:0] d3, d2, d1, d0;
    if (v > 9999) return {1'b1, 16'hEEEE};
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {1'b0, d3, d2, d1, d0};
  endfunction

  // Reference model: a request is accepted when idle, result appears 17 edges later
  int          m_left = 0;
  logic [15:0] m_val  = '0;
  logic [15:0] e_bcd  = '0;
  logic        e_ovf  = 1'b0;
  logic        e_done = 1'b0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_left <= 0;
      e_bcd  <= '0;
      e_ovf  <= 1'b0;
      e_done <= 1'b0;
    end else begin
      e_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          {e_ovf, e_bcd} <= golden(32'(m_val));
          e_done <= 1'b1;
        end
      end else if (start) begin
        m_val  <= bin;
        m_left <= 17;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_left != 0));
    check("done", 32'(done), 32'(e_done));
    check("bcd",  32'(bcd),  32'(e_bcd));
    check("ovf",  32'(ovf),  32'(e_ovf));
    if (busy && done) check("busy_done_excl", 32'(1), 32'(0));
  end

  // Issue one request and wait (bounded) for its done; reports busy cycles seen
  task automatic convert(input logic [15:0] v, output int busy_n, output int done_cyc);
    bit seen;
    seen = 0;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = 16'($urandom);
    busy_n = busy ? 1 : 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        done_cyc = cyc;
      end else if (busy) begin
        busy_n++;
      end
    end
    if (!seen) check("done_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    int bn, dc, dc2, ndone;
    int unsigned v;
    logic [15:0] vals [4];
    logic [15:0] exp_bcd [4];
    logic        exp_ovf [4];

    clr   = 1'b1;
    start = 1'b0;
    bin   = '0;
    #1 clr = 1'b0;
    #20;
    check("reset_bcd",  32'(bcd),  32'h0);
    check("reset_ovf",  32'(ovf),  32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    @(negedge clk);
    clr = 1'b1;

    // Basic conversion and latency
    convert(16'd1234, bn, dc);
    check("lat_busy_cycles", 32'(bn), 32'd17);
    check("lit_1234", 32'(bcd), 32'h1234);
    check("lit_1234_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'h0);

    // Boundaries
    vals[0] = 16'd0;     exp_bcd[0] = 16'h0000; exp_ovf[0] = 1'b0;
    vals[1] = 16'd9999;  exp_bcd[1] = 16'h9999; exp_ovf[1] = 1'b0;
    vals[2] = 16'd10000; exp_bcd[2] = 16'hEEEE; exp_ovf[2] = 1'b1;
    vals[3] = 16'd65535; exp_bcd[3] = 16'hEEEE; exp_ovf[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      convert(vals[i], bn, dc);
      check("bnd_bcd", 32'(bcd), 32'(exp_bcd[i]));
      check("bnd_ovf", 32'(ovf), 32'(exp_ovf[i]));
    end

    // Start during busy is ignored
    @(negedge clk);
    start = 1'b1; bin = 16'd42;
    @(negedge clk);
    start = 1'b0; bin = 16'd3;
    repeat (3) @(negedge clk);
    start = 1'b1; bin = 16'd7;
    @(negedge clk);
    start = 1'b0; bin = 16'd9000;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignore_ndone", 32'(ndone), 32'd1);
    check("ignore_bcd", 32'(bcd), 32'h0042);

    // Start held high: back-to-back every 18 cycles
    @(negedge clk);
    start = 1'b1; bin = 16'd5;
    dc = -1;
    for (int k = 0; k < 30 && dc < 0; k++) begin
      @(negedge clk);
      if (done) dc = cyc;
    end
    check("b2b_first", 32'(bcd), 32'h0005);
    check("b2b_gap_busy", 32'(busy), 32'h0);
    bin = 16'd87;
    @(negedge clk);
    start = 1'b0;
    dc2 = -1;
    for (int k = 0; k < 30 && dc2 < 0; k++) begin
      @(negedge clk);
      if (done) dc2 = cyc;
    end
    check("b2b_second", 32'(bcd), 32'h0087);
    check("b2b_spacing", 32'(dc2 - dc), 32'd18);

    // Reset aborts an in-flight conversion
    convert(16'd4321, bn, dc);
    check("pre_abort", 32'(bcd), 32'h4321);
    @(negedge clk);
    start = 1'b1; bin = 16'd99;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    check("abort_bcd",  32'(bcd),  32'h0);
    check("abort_ovf",  32'(ovf),  32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (k == 3) clr = 1'b1;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    convert(16'd99, bn, dc);
    check("after_abort", 32'(bcd), 32'h0099);

    // Sweep, half biased into the representable range
    for (int i = 0; i < 2000; i++) begin
      v = (i % 2 == 1) ? $urandom_range(9999, 0) : $urandom_range(65535, 0);
      convert(16'(v), bn, dc);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
